sn74hc165_reader: RTL
=====================

SN74HC165_READER -- requirements
Module: sn74hc165_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per scan (8 per chained 74HC165, legal 8..64).
REQ-002 SHALL have parameter BIT_HALF, default 500, meaning clk cycles per half serial-clock period (legal >= 4).
REQ-003 SHALL have parameter SCAN_GAP, default 1000, meaning idle clk cycles between scans (legal >= 1).
REQ-004 SHALL have port clk  input  1  system clock; the only clock in the block.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port SN74HC165_data  input  1  serial data from QH of the last chained 74HC165; asynchronous to clk.
REQ-007 SHALL have port SN74HC165_clk  output  1  serial shift clock to CLK pin; registered.
REQ-008 SHALL have port SN74HC165_load_n  output  1  SH/LD_n pin; low = parallel load; registered.
REQ-009 SHALL have port o_buf  output  DATA_W  last completed scan; holds between scans.
REQ-010 SHALL have port o_valid  output  1  one-clk pulse when o_buf updates.
REQ-011 SHALL have port o_changed  output  1  one-clk pulse, coincident with o_valid, when new o_buf differs from the previous value.

Function
REQ-012 SHALL pass SN74HC165_data through a 2-flop synchronizer before any use.
REQ-013 SHALL implement FSM states GAP, LOAD, SHIFT_LO, SHIFT_HI, DONE.
REQ-014 GAP SHALL last SCAN_GAP cycles (load_n=1, clk=0), then go to LOAD.
REQ-015 LOAD SHALL last BIT_HALF cycles (load_n=0, clk=0), then go to SHIFT_LO with bit index 0.
REQ-016 SHIFT_LO SHALL last BIT_HALF cycles (load_n=1, clk=0) and SHALL sample the synchronized data into the shift register in its last cycle.
REQ-017 After a SHIFT_LO sample with bit index < DATA_W-1, the FSM SHALL go to SHIFT_HI.
REQ-018 After the SHIFT_LO sample with bit index = DATA_W-1, the FSM SHALL go to DONE with no further rising edge on SN74HC165_clk.
REQ-019 SHIFT_HI SHALL last BIT_HALF cycles (load_n=1, clk=1), then increment the bit index and return to SHIFT_LO.
REQ-020 Bit order SHALL be MSB first: sample 0 -> o_buf[DATA_W-1], sample DATA_W-1 -> o_buf[0].
REQ-021 DONE SHALL last 1 cycle; in it, o_buf SHALL load the shift register and o_valid SHALL be 1.
REQ-022 In DONE, o_changed SHALL be 1 if the new value differs from the old o_buf, or if this is the first scan after reset.
REQ-023 After DONE, the FSM SHALL go to GAP.
REQ-024 Scan period SHALL be exactly SCAN_GAP + 2*DATA_W*BIT_HALF + 1 clk cycles, measured o_valid to o_valid.
REQ-025 SN74HC165_clk SHALL produce exactly DATA_W-1 rising edges per scan; load_n SHALL produce exactly one low pulse of BIT_HALF cycles per scan.
REQ-026 SN74HC165_load_n and SN74HC165_clk SHALL never both be active (load_n=0 with clk=1).
REQ-027 Counters SHALL be sized to clog2 of their maximum count; no wrap-around SHALL occur within a state.

Reset
REQ-028 While rst_n=0, outputs SHALL be: SN74HC165_clk=0, load_n=1, o_buf=0, o_valid=0, o_changed=0; FSM=GAP; all counters and synchronizer flops=0.
REQ-029 Assertion of rst_n mid-scan SHALL abort the scan; no o_valid SHALL be produced and o_buf SHALL clear to 0.
REQ-030 After release of rst_n, the first o_valid SHALL occur exactly SCAN_GAP + 2*DATA_W*BIT_HALF + 1 cycles later, and the scan SHALL start in GAP.

Verification (DATA_W=8, BIT_HALF=4, SCAN_GAP=8, behavioural 74HC165 model)
REQ-031 Scenario: model inputs 0xA5 -> o_buf=0xA5 with o_valid and o_changed high 73 cycles after reset release.
REQ-032 Scenario: inputs held at 0xA5 for the second scan -> o_valid high, o_changed low, o_buf=0xA5, 73 cycles after the first o_valid.
REQ-033 Scenario: inputs changed to 0x01 mid-GAP -> next scan o_buf=0x01 with o_changed=1 (checks bit order, LSB at o_buf[0]).
REQ-034 Scenario: count edges per scan -> 7 rising edges on SN74HC165_clk, one 4-cycle load_n low pulse, never load_n=0 with clk=1.
REQ-035 Scenario: rst_n pulsed during SHIFT_HI of bit 3 -> outputs take reset values immediately; no o_valid from the aborted scan; next o_valid 73 cycles after release.
REQ-036 Scenario: DATA_W=16 with two chained models holding 0x1234 -> o_buf=0x1234, scan period 137 cycles.

Source files
------------

// File: rtl/sn74hc165_reader.sv
// Periodically scans a chain of 74HC165 parallel-in/serial-out shift registers, MSB first,
// and presents the last completed scan with valid/changed pulses.
module sn74hc165_reader #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned BIT_HALF = 500,
   parameter int unsigned SCAN_GAP = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SN74HC165_data,
   output logic              SN74HC165_clk,
   output logic              SN74HC165_load_n,
   output logic [DATA_W-1:0] o_buf,
   output logic              o_valid,
   output logic              o_changed
);

   localparam int unsigned CntMax = (SCAN_GAP > BIT_HALF) ? SCAN_GAP : BIT_HALF;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam int unsigned IdxW   = $clog2(DATA_W);

   localparam logic [CntW-1:0] GapEnd  = CntW'(SCAN_GAP);
   localparam logic [CntW-1:0] HalfEnd = CntW'(BIT_HALF - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

   typedef enum logic [2:0] {StGap, StLoad, StShiftLo, StShiftHi, StDone} state_e;

   state_e            state_q;
   logic [CntW-1:0]   cnt_q;
   logic [IdxW-1:0]   idx_q;
   logic [DATA_W-1:0] shreg_q;
   logic [1:0]        sync_q;
   logic              seen_q;
   logic [DATA_W-1:0] shreg_d;

   assign shreg_d = {shreg_q[DATA_W-2:0], sync_q[1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= StGap;
         cnt_q            <= '0;
         idx_q            <= '0;
         shreg_q          <= '0;
         sync_q           <= '0;
         seen_q           <= 1'b0;
         SN74HC165_clk    <= 1'b0;
         SN74HC165_load_n <= 1'b1;
         o_buf            <= '0;
         o_valid          <= 1'b0;
         o_changed        <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], SN74HC165_data};
         o_valid   <= 1'b0;
         o_changed <= 1'b0;
         unique case (state_q)
            // GAP ends at SCAN_GAP; DONE re-enters it at 1, so release-to-first-valid and
            // valid-to-valid both equal SCAN_GAP + 2*DATA_W*BIT_HALF + 1.
            StGap: begin
               if (cnt_q == GapEnd) begin
                  state_q          <= StLoad;
                  cnt_q            <= '0;
                  SN74HC165_load_n <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StLoad: begin
               if (cnt_q == HalfEnd) begin
                  state_q          <= StShiftLo;
                  cnt_q            <= '0;
                  idx_q            <= '0;
                  SN74HC165_load_n <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StShiftLo: begin
               if (cnt_q == HalfEnd) begin
                  shreg_q <= shreg_d;
                  cnt_q   <= '0;
                  if (idx_q == IdxLast) begin
                     state_q   <= StDone;
                     o_buf     <= shreg_d;
                     o_valid   <= 1'b1;
                     o_changed <= !seen_q || (shreg_d != o_buf);
                     seen_q    <= 1'b1;
                  end else begin
                     state_q       <= StShiftHi;
                     SN74HC165_clk <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StShiftHi: begin
               if (cnt_q == HalfEnd) begin
                  state_q       <= StShiftLo;
                  cnt_q         <= '0;
                  idx_q         <= idx_q + 1'b1;
                  SN74HC165_clk <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StDone: begin
               state_q <= StGap;
               cnt_q   <= CntW'(1);
            end
            default: state_q <= StGap;
         endcase
      end
   end

endmodule
